display_capture: RTL and testbench
==================================

Name: display_capture

Overview:
- Receiver side of the multiplexed 7-segment display interface: watches the abcdefgh/digit lines driven by the display driver and reconstructs the displayed hex number, decimal points and pattern errors.
- Used in the FPGA top for loopback self-check and for display mirroring on other outputs, such as UART or VGA, and in simulation as a display monitor.
- Presents a complete frame only after every digit position has been captured.

Parameters:
- n_dig, 4, number of digits; must be at least 2.
- settle, 4, consecutive identical samples needed before a digit is captured; must be at least 1.
- timeout_w, 20, width of the inactivity counter; timeout is 2**timeout_w cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- abcdefgh  in  8  segment lines, active-low; bit 7 = a ... bit 1 = g, bit 0 = h (dot)
- digit  in  n_dig  digit enables, active-low one-hot; bit k low selects nibble k
- number  out  n_dig*4  last complete frame; nibble k = number[k*4 +: 4]
- dots  out  n_dig  dot state per digit in the last frame, 1 = lit
- bad  out  n_dig  per digit in the last frame, 1 = segment pattern was not a hex glyph
- frame_valid  out  1  one-cycle pulse when number, dots and bad are updated
- active  out  1  1 while captures occur within the timeout window

Behaviour:
- Reset, asynchronous: number=0, dots=0, bad=0, frame_valid=0, active=0. All internal state cleared: sample register, stability counter, captured flag, shadow registers, seen mask, timeout counter.
- Stage 1 registers abcdefgh and digit every cycle. All decisions below use the registered sample.
- Sample is well-formed only when exactly one bit of digit is 0.
- Stability counter:
  - Counts up, saturating, while the registered sample equals the previous registered sample and is well-formed.
  - Otherwise it loads 0 and clears the captured flag.
- Capture:
  - Occurs on the cycle the counter reaches settle-1 with the captured flag clear.
  - Sets the captured flag, so there is exactly one capture per stable interval.
  - With settle=1, capture occurs on the first well-formed sample following any change.
  - Worst-case latency from input change to capture: settle+1 cycles.
- Decode at capture, for slot k = index of the low digit bit:
  - Bits 7:1 are compared with the 16 glyphs 0-F (active-low, a..g):
    - 0000001 0, 1001111 1, 0010010 2, 0000110 3
    - 1001100 4, 0100100 5, 0100000 6, 0001111 7
    - 0000000 8, 0001100 9, 0001000 A, 1100000 b
    - 0110001 C, 1000010 d, 0110000 E, 0111000 F
  - Match: shadow nibble k = value, shadow bad k = 0.
  - No match (including blank 1111111): shadow nibble k = 0, shadow bad k = 1.
  - Shadow dot k = ~bit 0.
  - Seen mask bit k is set.
- Recapturing a slot already in the seen mask overwrites its shadow entries; no frame is produced.
- Frame completion:
  - Triggered by the capture that makes the seen mask all ones.
  - Next cycle: number, dots and bad are loaded from the shadow, including that capture; frame_valid=1 for one cycle; seen mask cleared.
  - Outputs hold between frames.
- Samples that are not well-formed (all digit bits high, or two or more low) are ignored. They do not change shadow, mask or outputs.
- Timeout:
  - Counter is cleared on each capture and otherwise increments, saturating at all ones.
  - active=1 from the cycle after any capture.
  - active=0 once the counter saturates; the seen mask is also cleared at that point.
  - number, dots and bad retain their last values.
- Reset mid-frame discards any partial frame; the first frame after reset needs all n_dig captures.
- Only one capture is possible per cycle. A frame completion and a new capture cannot coincide because of settle spacing. If a reset and a capture coincide, reset wins.

Test Plan:
- Driver-style rotation, settle=4, each digit held 16 cycles, number 16'h1A3F, dots off -> after 4 captures one frame_valid pulse, number=16'h1A3F, dots=0, bad=0, active=1.
- Same stream, but nibble 2 is driven with 8'h00 (8 with dot) -> number=16'h183F, dots=4'b0100.
- Glitch: digit 1 shows 8'b10011111 for 3 cycles, then 8'b00000011 steady -> only the steady value is captured, nibble 1=0; no capture of 1.
- Blank 8'hFF on digit 3 -> bad=4'b1000, nibble 3=0, frame still valid. Digit 4'b1100 or 4'b1111 held for 100 cycles -> no capture, mask unchanged.
- Stop toggling for 2**timeout_w cycles with timeout_w=6 -> active falls after 64 idle cycles; number holds; the next frame needs all 4 captures.
- Assert reset after 2 of 4 captures -> outputs 0 immediately. A fresh full rotation of 16'h5E00 -> single frame_valid, number=16'h5E00.

Source files
------------

// File: rtl/display_capture.sv
// Receiver for a multiplexed 7-segment display bus: samples the segment/digit
// lines, debounces each digit and reassembles complete hex frames.
module display_capture #(
  parameter int unsigned n_dig     = 4,
  parameter int unsigned settle    = 4,
  parameter int unsigned timeout_w = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           abcdefgh,
  input  logic [n_dig-1:0]     digit,
  output logic [n_dig*4-1:0]   number,
  output logic [n_dig-1:0]     dots,
  output logic [n_dig-1:0]     bad,
  output logic                 frame_valid,
  output logic                 active
);

  localparam int unsigned CNT_W = (settle > 1) ? $clog2(settle) : 1;
  localparam int unsigned IDX_W = $clog2(n_dig);
  localparam int unsigned NUM_W = n_dig * 4;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(settle - 1);

  logic [7:0]           seg_q, seg_d, seg_p_q, seg_p_d;
  logic [n_dig-1:0]     dig_q, dig_d, dig_p_q, dig_p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 captured_q, captured_d;
  logic [NUM_W-1:0]     sh_num_q, sh_num_d;
  logic [n_dig-1:0]     sh_dot_q, sh_dot_d;
  logic [n_dig-1:0]     sh_bad_q, sh_bad_d;
  logic [n_dig-1:0]     seen_q, seen_d;
  logic [timeout_w-1:0] tmo_q, tmo_d;
  logic [NUM_W-1:0]     number_q, number_d;
  logic [n_dig-1:0]     dots_q, dots_d;
  logic [n_dig-1:0]     bad_q, bad_d;
  logic                 fv_q, fv_d;
  logic                 active_q, active_d;

  logic                 well_formed_c;
  logic                 same_c;
  logic                 captured_eff_c;
  logic                 capture_c;
  logic [IDX_W-1:0]     slot_c;
  logic [4:0]           glyph_c;

  // Returns {hit, value} for an active-low a..g pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0001100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    seg_d      = abcdefgh;
    dig_d      = digit;
    seg_p_d    = seg_q;
    dig_p_d    = dig_q;
    cnt_d      = '0;
    captured_d = captured_q;
    sh_num_d   = sh_num_q;
    sh_dot_d   = sh_dot_q;
    sh_bad_d   = sh_bad_q;
    seen_d     = seen_q;
    tmo_d      = (tmo_q == '1) ? tmo_q : tmo_q + timeout_w'(1);
    number_d   = number_q;
    dots_d     = dots_q;
    bad_d      = bad_q;
    fv_d       = 1'b0;
    active_d   = active_q;
    captured_eff_c = 1'b0;
    slot_c     = '0;

    well_formed_c = ($countones(~dig_q) == 1);
    same_c        = (seg_q == seg_p_q) && (dig_q == dig_p_q);
    glyph_c       = decode(seg_q[7:1]);

    // Stability counter; any change or malformed sample restarts the interval.
    if (same_c && well_formed_c) begin
      cnt_d          = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_W'(1);
      captured_eff_c = captured_q;
    end
    capture_c  = well_formed_c && (cnt_d == CNT_TOP) && !captured_eff_c;
    captured_d = captured_eff_c | capture_c;

    for (int k = 0; k < n_dig; k++) begin
      if (!dig_q[k]) slot_c = IDX_W'(k);
    end

    if (capture_c) begin
      sh_num_d[{slot_c, 2'b00} +: 4] = glyph_c[4] ? glyph_c[3:0] : 4'h0;
      sh_bad_d[slot_c] = ~glyph_c[4];
      sh_dot_d[slot_c] = ~seg_q[0];
      seen_d[slot_c]   = 1'b1;
      tmo_d            = '0;
      active_d         = 1'b1;
      // Publish the frame once every position has been captured.
      if (&seen_d) begin
        number_d = sh_num_d;
        dots_d   = sh_dot_d;
        bad_d    = sh_bad_d;
        fv_d     = 1'b1;
        seen_d   = '0;
      end
    end else if (tmo_d == '1) begin
      active_d = 1'b0;
      seen_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q      <= '0;
      dig_q      <= '0;
      seg_p_q    <= '0;
      dig_p_q    <= '0;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      sh_num_q   <= '0;
      sh_dot_q   <= '0;
      sh_bad_q   <= '0;
      seen_q     <= '0;
      tmo_q      <= '0;
      number_q   <= '0;
      dots_q     <= '0;
      bad_q      <= '0;
      fv_q       <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      dig_q      <= dig_d;
      seg_p_q    <= seg_p_d;
      dig_p_q    <= dig_p_d;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      sh_num_q   <= sh_num_d;
      sh_dot_q   <= sh_dot_d;
      sh_bad_q   <= sh_bad_d;
      seen_q     <= seen_d;
      tmo_q      <= tmo_d;
      number_q   <= number_d;
      dots_q     <= dots_d;
      bad_q      <= bad_d;
      fv_q       <= fv_d;
      active_q   <= active_d;
    end
  end

  assign number      = number_q;
  assign dots        = dots_q;
  assign bad         = bad_q;
  assign frame_valid = fv_q;
  assign active      = active_q;

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture: expected frames are queued as digits are
// driven and popped when frame_valid pulses.
module tb_display_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic [15:0] number;
  logic [3:0]  dots;
  logic [3:0]  bad;
  logic        frame_valid;
  logic        active;

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  dts;
    logic [3:0]  bd;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp    = 0;
  int n_bad    = 0;
  int n_frames = 0;
  int frames_before;

  display_capture #(.n_dig(4), .settle(4), .timeout_w(6)) dut (
    .clk(clk), .reset(reset), .abcdefgh(abcdefgh), .digit(digit),
    .number(number), .dots(dots), .bad(bad),
    .frame_valid(frame_valid), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] v, input logic dot);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b0000001;  4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;  4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;  4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;  4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0001100;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;  4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;  default: g = 7'b0111000;
    endcase
    return {g, ~dot};
  endfunction

  // One clock; sample just after the edge and score any frame pulse.
  task automatic tick();
    frame_t e;
    @(posedge clk);
    #1;
    if (frame_valid) begin
      n_frames++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_pulse", 32'(frame_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("frame_number", 32'(number), 32'(e.num));
        check("frame_dots",   32'(dots),   32'(e.dts));
        check("frame_bad",    32'(bad),    32'(e.bd));
      end
    end
  endtask

  task automatic show(input int k, input logic [7:0] seg, input int n);
    digit    = ~(4'b0001 << k);
    abcdefgh = seg;
    repeat (n) tick();
  endtask

  task automatic rotate(input logic [15:0] num, input logic [3:0] dts);
    for (int k = 0; k < 4; k++) show(k, glyph(num[k*4 +: 4], dts[k]), 16);
  endtask

  task automatic expect_frame(input logic [15:0] n, input logic [3:0] d, input logic [3:0] b);
    frame_t f;
    f.num = n;
    f.dts = d;
    f.bd  = b;
    exp_q.push_back(f);
  endtask

  initial begin
    reset    = 1'b1;
    digit    = 4'hF;
    abcdefgh = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_number", 32'(number), 32'd0);
    check("reset_dots", 32'(dots), 32'd0);
    check("reset_bad", 32'(bad), 32'd0);
    check("reset_frame_valid", 32'(frame_valid), 32'd0);
    check("reset_active", 32'(active), 32'd0);
    reset = 1'b0;
    tick();

    // Plain rotation
    expect_frame(16'h1A3F, 4'h0, 4'h0);
    rotate(16'h1A3F, 4'h0);
    check("rot_pending", 32'(exp_q.size()), 32'd0);
    check("rot_frames", 32'(n_frames), 32'd1);
    check("rot_active", 32'(active), 32'd1);

    // Digit 2 shows 8 with dot (8'h00)
    expect_frame(16'h183F, 4'b0100, 4'h0);
    rotate(16'h183F, 4'b0100);
    check("dot_pending", 32'(exp_q.size()), 32'd0);
    check("dot_frames", 32'(n_frames), 32'd2);

    // Short glitch showing 1 on digit 1 must not be captured
    expect_frame(16'h1A0F, 4'h0, 4'h0);
    show(0, glyph(4'hF, 1'b0), 16);
    show(1, 8'b10011111, 3);
    show(1, 8'b00000011, 16);
    show(2, glyph(4'hA, 1'b0), 16);
    show(3, glyph(4'h1, 1'b0), 16);
    check("glitch_pending", 32'(exp_q.size()), 32'd0);
    check("glitch_number", 32'(number), 32'h1A0F);

    // Malformed digit enables mid-frame, then a blank digit 3
    expect_frame(16'h0A3F, 4'h0, 4'b1000);
    show(0, glyph(4'hF, 1'b0), 16);
    show(1, glyph(4'h3, 1'b0), 16);
    digit = 4'b1100; abcdefgh = glyph(4'h5, 1'b0);
    repeat (20) tick();
    digit = 4'b1111;
    repeat (20) tick();
    show(2, glyph(4'hA, 1'b0), 16);
    show(3, 8'hFF, 16);
    check("blank_pending", 32'(exp_q.size()), 32'd0);
    check("blank_bad", 32'(bad), 32'h8);
    check("blank_number", 32'(number), 32'h0A3F);
    check("blank_frames", 32'(n_frames), 32'd4);

    // Inactivity timeout discards partial frame
    show(0, glyph(4'h7, 1'b0), 16);
    show(1, glyph(4'h6, 1'b0), 60);
    check("idle_active_before", 32'(active), 32'd1);
    repeat (15) tick();
    check("idle_active_after", 32'(active), 32'd0);
    check("idle_number_holds", 32'(number), 32'h0A3F);
    frames_before = n_frames;
    show(2, glyph(4'hC, 1'b0), 16);
    show(3, glyph(4'hD, 1'b0), 16);
    check("idle_no_early_frame", 32'(n_frames), 32'(frames_before));
    expect_frame(16'hDC98, 4'h0, 4'h0);
    show(0, glyph(4'h8, 1'b0), 16);
    show(1, glyph(4'h9, 1'b0), 16);
    check("idle_pending", 32'(exp_q.size()), 32'd0);
    check("idle_number", 32'(number), 32'hDC98);

    // Reset mid-frame
    show(0, glyph(4'h0, 1'b0), 16);
    show(1, glyph(4'h0, 1'b0), 16);
    reset = 1'b1;
    #1;
    check("mid_reset_number", 32'(number), 32'd0);
    check("mid_reset_active", 32'(active), 32'd0);
    check("mid_reset_bad", 32'(bad), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    frames_before = n_frames;
    show(3, glyph(4'h5, 1'b0), 16);
    show(2, glyph(4'hE, 1'b0), 16);
    check("post_reset_no_frame", 32'(n_frames), 32'(frames_before));
    expect_frame(16'h5E00, 4'h0, 4'h0);
    show(0, glyph(4'h0, 1'b0), 16);
    show(1, glyph(4'h0, 1'b0), 16);
    check("post_reset_pending", 32'(exp_q.size()), 32'd0);
    check("post_reset_frames", 32'(n_frames), 32'(frames_before + 1));
    check("post_reset_number", 32'(number), 32'h5E00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
